// File: rtl/norm_div_if.sv
// Handshake bundle for the normalization stage: input vector/denominator and normalized output.
interface norm_div_if #(
  parameter int unsigned Col    = 8,
  parameter int unsigned BwPsum = 20,
  parameter int unsigned SumBw  = 24,
  parameter int unsigned Obw    = 12
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [Col*BwPsum-1:0] psum_in;
  logic [SumBw-1:0]      sum_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [Col*Obw-1:0]    norm_out;
  logic                  div_zero;

  modport master (
    output in_valid, psum_in, sum_in, out_ready,
    input  in_ready, out_valid, norm_out, div_zero
  );

  modport slave (
    input  in_valid, psum_in, sum_in, out_ready,
    output in_ready, out_valid, norm_out, div_zero
  );
endinterface

// File: rtl/norm_div.sv
// Normalizes a vector of signed psums by a shared denominator using one sequential
// restoring divider, one quotient bit per cycle, elements processed back to back.
module norm_div #(
  parameter int unsigned Col    = 8,
  parameter int unsigned BwPsum = 20,
  parameter int unsigned SumBw  = 24,
  parameter int unsigned Frac   = 8,
  parameter int unsigned Obw    = 12
) (
  input  logic       clk,
  input  logic       reset,
  norm_div_if.slave  bus
);
  localparam int unsigned Dw   = BwPsum + Frac;
  localparam int unsigned IdxW = (Col > 1) ? $clog2(Col) : 1;
  localparam int unsigned CntW = $clog2(Dw);
  localparam logic [Dw-1:0] MaxPos = Dw'(2 ** (Obw - 1) - 1);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e            r_state;
  logic [BwPsum-1:0] r_psum [Col];
  logic [SumBw-1:0]  r_sum;
  logic [IdxW-1:0]   r_idx;
  logic [CntW-1:0]   r_cnt;
  logic [SumBw:0]    r_rem;
  logic [Dw-1:0]     r_quot;
  logic [Obw-1:0]    r_norm [Col];
  logic              r_div_zero;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [BwPsum-1:0] w_elem;
  logic [BwPsum-1:0] w_mag;
  logic [Dw-1:0]     w_dividend;
  logic [CntW-1:0]   w_bit_sel;
  logic [SumBw:0]    w_trial;
  logic              w_qbit;
  logic [SumBw:0]    w_rem_next;
  logic [Dw-1:0]     w_quot_next;
  logic [Obw-1:0]    w_sat;
  logic [Obw-1:0]    w_result;
  logic              w_last_bit;

  always_comb begin
    w_elem      = r_psum[r_idx];
    // Two's-complement negate in BwPsum-bit unsigned space keeps -2^(BwPsum-1) exact.
    w_mag       = w_elem[BwPsum-1] ? (~w_elem + 1'b1) : w_elem;
    w_dividend  = {w_mag, {Frac{1'b0}}};
    w_bit_sel   = CntW'(Dw - 1) - r_cnt;
    w_trial     = {r_rem[SumBw-1:0], w_dividend[w_bit_sel]};
    // The remainder never reaches bit SumBw; folding it in keeps the test honest.
    w_qbit      = r_rem[SumBw] || (w_trial >= {1'b0, r_sum});
    w_rem_next  = w_qbit ? (w_trial - {1'b0, r_sum}) : w_trial;
    w_quot_next = {r_quot[Dw-2:0], w_qbit};
    w_sat       = (w_quot_next > MaxPos) ? MaxPos[Obw-1:0] : w_quot_next[Obw-1:0];
    w_result    = w_elem[BwPsum-1] ? (~w_sat + 1'b1) : w_sat;
    w_last_bit  = (r_cnt == CntW'(Dw - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_sum       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_div_zero  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < Col; i++) begin
        r_psum[i] <= '0;
        r_norm[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid && r_in_ready) begin
            for (int i = 0; i < Col; i++) begin
              r_psum[i] <= bus.psum_in[i*BwPsum +: BwPsum];
              r_norm[i] <= '0;
            end
            r_sum      <= bus.sum_in;
            r_div_zero <= (bus.sum_in == '0);
            r_idx      <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_in_ready <= 1'b0;
            if (bus.sum_in == '0) begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= StDiv;
            end
          end
        end
        StDiv: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last_bit) begin
            r_norm[r_idx] <= w_result;
            r_rem         <= '0;
            r_quot        <= '0;
            r_cnt         <= '0;
            if (r_idx == IdxW'(Col - 1)) begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.div_zero  = r_div_zero;

  for (genvar g = 0; g < Col; g++) begin : g_pack
    assign bus.norm_out[g*Obw +: Obw] = r_norm[g];
  end
endmodule

// File: tb/tb_norm_div.sv
// Directed bench for norm_div: latency, values, saturation, zero divisor, back-pressure, reset.
module tb_norm_div;
  localparam int unsigned Col    = 8;
  localparam int unsigned BwPsum = 20;
  localparam int unsigned SumBw  = 24;
  localparam int unsigned Frac   = 8;
  localparam int unsigned Obw    = 12;
  localparam int          Lat    = 224;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  norm_div_if #(.Col(Col), .BwPsum(BwPsum), .SumBw(SumBw), .Obw(Obw)) bus ();

  norm_div #(
    .Col(Col), .BwPsum(BwPsum), .SumBw(SumBw), .Frac(Frac), .Obw(Obw)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [Col*BwPsum-1:0] pack(input int a0, input int a1, input int a2,
                                                 input int a3, input int a4, input int a5,
                                                 input int a6, input int a7);
    int v [Col];
    logic [Col*BwPsum-1:0] r;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    for (int i = 0; i < Col; i++) r[i*BwPsum +: BwPsum] = BwPsum'(v[i]);
    return r;
  endfunction

  function automatic int elem(input int i);
    logic signed [Obw-1:0] e;
    e = bus.norm_out[i*Obw +: Obw];
    return int'(e);
  endfunction

  // Returns at the falling edge just after the accept edge.
  task automatic send(input logic [Col*BwPsum-1:0] p, input logic [SumBw-1:0] s,
                      input bit hold);
    int k;
    k = 0;
    @(negedge clk);
    bus.psum_in  = p;
    bus.sum_in   = s;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      n_tests++; n_fail++;
      $display("FAIL send_accept: in_ready got %b want 1 within 1000 cycles", bus.in_ready);
    end
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.psum_in = '0; bus.sum_in = '0;
    #12;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_tests++; if (bus.norm_out !== '0) begin n_fail++;
      $display("FAIL reset_norm_out got %h want 0", bus.norm_out); end
    n_tests++; if (bus.div_zero !== 1'b0) begin n_fail++;
      $display("FAIL reset_div_zero got %b want 0", bus.div_zero); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    int e [Col];
    e = '{64, -128, 0, 256, 16, -16, 32, 48};
    send(pack(4, -8, 0, 16, 1, -1, 2, 3), 24'd16, 1'b0);
    wait_out(lat);
    n_tests++; if (lat !== Lat) begin n_fail++;
      $display("FAIL basic_latency got %0d want %0d", lat, Lat); end
    for (int i = 0; i < Col; i++) begin
      n_tests++; if (elem(i) !== e[i]) begin n_fail++;
        $display("FAIL basic_elem%0d got %0d want %0d", i, elem(i), e[i]); end
    end
    n_tests++; if (bus.div_zero !== 1'b0) begin n_fail++;
      $display("FAIL basic_div_zero got %b want 0", bus.div_zero); end
    consume();
  endtask

  task automatic test_saturation();
    int lat;
    int e [Col];
    e = '{2047, -2047, 0, 0, 0, 0, 0, 0};
    send(pack(1000, -1000, 0, 0, 0, 0, 0, 0), 24'd100, 1'b0);
    wait_out(lat);
    for (int i = 0; i < Col; i++) begin
      n_tests++; if (elem(i) !== e[i]) begin n_fail++;
        $display("FAIL sat_elem%0d got %0d want %0d", i, elem(i), e[i]); end
    end
    consume();
  endtask

  task automatic test_extreme_neg();
    int lat;
    send(pack(-524288, 0, 0, 0, 0, 0, 0, 0), 24'h800000, 1'b0);
    wait_out(lat);
    n_tests++; if (elem(0) !== -16) begin n_fail++;
      $display("FAIL extreme_elem0 got %0d want -16", elem(0)); end
    n_tests++; if (bus.norm_out[Col*Obw-1:Obw] !== '0) begin n_fail++;
      $display("FAIL extreme_rest got %h want 0", bus.norm_out[Col*Obw-1:Obw]); end
    consume();
  endtask

  task automatic test_div_zero();
    int lat;
    // Zero divisor skips the divider: out_valid is already up in the cycle after accept.
    send(pack(5, -7, 100, 3, -9, 1, 2, 4), 24'd0, 1'b0);
    wait_out(lat);
    n_tests++; if (lat !== 0) begin n_fail++;
      $display("FAIL zero_latency got %0d want 0", lat); end
    n_tests++; if (bus.norm_out !== '0) begin n_fail++;
      $display("FAIL zero_norm_out got %h want 0", bus.norm_out); end
    n_tests++; if (bus.div_zero !== 1'b1) begin n_fail++;
      $display("FAIL zero_div_zero got %b want 1", bus.div_zero); end
    consume();
    send(pack(4, -8, 0, 16, 1, -1, 2, 3), 24'd16, 1'b0);
    wait_out(lat);
    n_tests++; if (bus.div_zero !== 1'b0) begin n_fail++;
      $display("FAIL zero_clear_div_zero got %b want 0", bus.div_zero); end
    n_tests++; if (elem(1) !== -128) begin n_fail++;
      $display("FAIL zero_next_elem1 got %0d want -128", elem(1)); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    int e [Col];
    logic [Col*Obw-1:0] held;
    e = '{64, -128, 0, 256, 16, -16, 32, 48};
    send(pack(1000, -1000, 0, 0, 0, 0, 0, 0), 24'd100, 1'b1);
    bus.psum_in = pack(4, -8, 0, 16, 1, -1, 2, 3);
    bus.sum_in  = 24'd16;
    wait_out(lat);
    n_tests++; if (lat !== Lat) begin n_fail++;
      $display("FAIL bp_latency got %0d want %0d", lat, Lat); end
    held = bus.norm_out;
    bad  = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.norm_out !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++;
      $display("FAIL bp_stable got %0d bad cycles want 0", bad); end
    n_tests++; if (elem(0) !== 2047 || elem(1) !== -2047) begin n_fail++;
      $display("FAIL bp_held_values got %0d,%0d want 2047,-2047", elem(0), elem(1)); end
    consume();
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_after_xfer got valid=%b ready=%b want 0,1", bus.out_valid,
               bus.in_ready); end
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_capture got in_ready=%b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    wait_out(lat);
    n_tests++; if (lat !== Lat) begin n_fail++;
      $display("FAIL bp_next_latency got %0d want %0d", lat, Lat); end
    for (int i = 0; i < Col; i++) begin
      n_tests++; if (elem(i) !== e[i]) begin n_fail++;
        $display("FAIL bp_next_elem%0d got %0d want %0d", i, elem(i), e[i]); end
    end
    consume();
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int bad;
    int e [Col];
    e = '{2047, -2047, 0, 0, 0, 0, 0, 0};
    send(pack(4, -8, 0, 16, 1, -1, 2, 3), 24'd16, 1'b0);
    repeat (99) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_flags got ready=%b valid=%b want 1,0", bus.in_ready,
               bus.out_valid); end
    n_tests++; if (bus.norm_out !== '0 || bus.div_zero !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_data got %h dz=%b want 0,0", bus.norm_out, bus.div_zero); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++;
      $display("FAIL rst_no_pulse got %0d valid cycles want 0", bad); end
    send(pack(1000, -1000, 0, 0, 0, 0, 0, 0), 24'd100, 1'b0);
    wait_out(lat);
    n_tests++; if (lat !== Lat) begin n_fail++;
      $display("FAIL rst_after_latency got %0d want %0d", lat, Lat); end
    for (int i = 0; i < Col; i++) begin
      n_tests++; if (elem(i) !== e[i]) begin n_fail++;
        $display("FAIL rst_after_elem%0d got %0d want %0d", i, elem(i), e[i]); end
    end
    consume();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_extreme_neg();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
